config_port_arbiter: RTL

Arbitrates the fabric configuration word port between the bitstream sources in the system clock domain: UART loader, USB DFU and SPI flash boot. It grants one source at a time for a whole bitstream session and forwards that source's words through a one-deep registered stage to the config frame writer. A session ends when the source signals done or stops sending for too long.

---
 rtl/config_arbiter_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/config_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/config_arbiter_pkg.sv
// Shared types and constants for the configuration port arbiter.
package config_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASE
  } arb_state_e;

  localparam int unsigned SRC_UART = 0;
  localparam int unsigned SRC_USB  = 1;
  localparam int unsigned SRC_SPI  = 2;

  // 100 ms at 12.5 MHz.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1250000;

  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester found after the previous
// owner, wrapping around, receives a one-hot grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0] last_idx;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    last_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (last[i]) last_idx = IdxW'(i);
    end
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_idx) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_port_arbiter.sv
// Grants the configuration word port to one bitstream source per session and
// forwards its words through a one-deep output register.
module config_port_arbiter
  import config_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk_system_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            done_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          cfg_valid_o,
  output logic [DATA_WIDTH-1:0]         cfg_data_o,
  input  logic                          cfg_ready_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFire = CntW'(TIMEOUT_CYCLES - 2);
  localparam logic [NUM_REQ-1:0] LastRst = NUM_REQ'(1) << (NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      last_q, last_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic [DATA_WIDTH-1:0]   cfg_data_q, cfg_data_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      pick;
  logic                    out_free;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   owner_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req_i),
    .last (last_q),
    .grant(pick)
  );

  assign out_free   = !cfg_valid_q || cfg_ready_i;
  assign accept     = (state_q == ACTIVE) && valid_i[owner_q] && out_free;
  assign owner_data = data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign ready_o    = (state_q == ACTIVE) ? (grant_q & {NUM_REQ{out_free}}) : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_data_d  = cfg_data_q;
    timeout_d   = 1'b0;

    if (cfg_ready_i) cfg_valid_d = 1'b0;
    if (accept) begin
      cfg_valid_d = 1'b1;
      cfg_data_d  = owner_data;
    end

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = ACTIVE;
          grant_d = pick;
          last_d  = pick;
          owner_d = IdxW'(onehot_to_idx(32'(pick)));
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          cnt_d = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A done pulse takes priority over a coincident timeout.
        if (done_i[owner_q]) begin
          state_d = RELEASE;
        end else if (!accept && cnt_q == CntFire) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!cfg_valid_q) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_system_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= LastRst;
      owner_q     <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_data_q  <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_data_q  <= cfg_data_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_o     = grant_q;
  assign cfg_valid_o = cfg_valid_q;
  assign cfg_data_o  = cfg_data_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule
